psa_simd_pipe: RTL and testbench
================================

Name: psa_simd_pipe

Overview:
- Parametrised successor to the team's 16-bit parallel sub-word adder (PADDSB datapath).
- Packed SIMD add/subtract over LANES signed lanes of LANE_W bits each.
- Selectable saturating or wrapping arithmetic; per-lane overflow flags and sticky error flags.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the ALU operand mux and writeback.

Parameters:
LANE_W, 4, bits per lane (>=2)
LANES, 4, number of lanes; data width DW = LANES*LANE_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  DW  operand A, lane i = a[i*LANE_W +: LANE_W]
b  in  DW  operand B, same packing
op  in  1  0 = a+b, 1 = a-b (sampled with beat)
sat_en  in  1  1 = saturate, 0 = wrap (sampled with beat)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
sum  out  DW  packed lane results
ovf  out  LANES  per-lane overflow for current result beat
err_sticky  out  LANES  per-lane sticky overflow
err_clr  in  1  clear err_sticky

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: s1_valid = 0, out_valid = 0, sum = 0, ovf = 0, err_sticky = 0. Any in-flight beats are dropped.
- Handshakes: input accepted on in_valid && in_ready; output consumed on out_valid && out_ready.
- Stage 1 (S1): registers a, b, op, sat_en. Computes per-lane raw result in LANE_W+1 bits, sign-extended: r = a_i + b_i, or r = a_i - b_i.
- Stage 2 (S2 / output): per lane, overflow = r outside [-2^(LANE_W-1), 2^(LANE_W-1)-1].
  - Overflow with sat_en=1: result = MAX on positive overflow, MIN on negative.
  - Overflow with sat_en=0: result = r[LANE_W-1:0].
  - No overflow: result = r[LANE_W-1:0].
  - ovf[i] is set on overflow in both modes.
- Stall/advance rules:
  - s2_load = !out_valid || out_ready
  - s1_adv = s1_valid && s2_load
  - in_ready = !s1_valid || s2_load (combinational, no dependence on in_valid)
- Throughput and latency:
  - 1 beat/cycle when out_ready is held high.
  - Latency: accepted at edge N -> out_valid at edge N+2.
- Stall hold: while out_valid && !out_ready, sum and ovf hold stable.
- Beats are never dropped or duplicated except at reset; order is preserved.
- Bubbles: if s2_load && !s1_valid, out_valid deasserts next edge. Data registers may hold stale values.
- Sticky flags: err_sticky[i] sets on an output handshake with ovf[i] = 1.
  - err_clr clears all bits.
  - Same cycle clear and set: the set wins for that lane; other lanes clear.
- op and sat_en apply per beat; mixed modes may be back-to-back.
- Lanes are fully independent; no carry crosses lane boundaries.
- Subtraction with b_i = MIN is correct via the LANE_W+1 extension (0 - MIN overflows).

Test Plan:
1. Defaults, op=0, sat_en=1, a=0x1234, b=0x1111 -> sum=0x2345, ovf=0000 at 2 cycles after accept; a=0x7777, b=0x1111 -> sum=0x7777, ovf=1111, err_sticky=1111.
2. Defaults, op=0, sat_en=0, a=0x7777, b=0x1111 -> sum=0x8888, ovf=1111.
3. Defaults, op=1, sat_en=1, a=0x8000, b=0x1000 -> sum=0x8000, ovf=1000; a=0x0000, b=0x8888 -> sum=0x7777, ovf=1111.
4. Backpressure: stream beats 0x0001..0x0005 + 0, out_ready=0 for 4 cycles.
   - in_ready drops after 2 beats held (S1 and S2 full).
   - sum holds stable while stalled.
   - After release, results 1..5 appear in order, no loss or duplication.
5. Sticky and reset: err_clr asserted in the same cycle as a handshake with ovf=0010 -> err_sticky=0010 next cycle.
   - rst asserted with S1 and S2 full -> next cycle out_valid=0, err_sticky=0, in_ready=1, pending beats gone.
6. LANE_W=8, LANES=2, op=0, sat_en=1, a=0x7F01, b=0x0101 -> sum=0x7F02, ovf=10; sat_en=0 -> sum=0x8002, ovf=10.

Source files
------------

// File: rtl/psa_simd_pipe.sv
// Packed SIMD signed add/subtract, LANES x LANE_W, with saturate or wrap per beat.
// Latency: a beat handshaken in the cycle after edge N is captured at N+1 and presented after N+2.
// Backpressure: the output holds while out_ready is low; in_ready drops only when S1 and S2 are both full.
module psa_simd_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*LANE_W-1:0]    a,
  input  logic [LANES*LANE_W-1:0]    b,
  input  logic                       op,
  input  logic                       sat_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*LANE_W-1:0]    sum,
  output logic [LANES-1:0]           ovf,
  output logic [LANES-1:0]           err_sticky,
  input  logic                       err_clr
);

  localparam int DW = LANES * LANE_W;

  // Saturation limits for one lane in two's complement.
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic          s1_valid;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic          s1_op;
  logic          s1_sat;

  logic          s2_load;
  logic          out_fire;

  logic [DW-1:0]    res_n;
  logic [LANES-1:0] ovf_n;
  logic [LANE_W:0]  ax;
  logic [LANE_W:0]  bx;
  logic [LANE_W:0]  rx;

  // S2 can take a new beat when it is empty or is being drained this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_fire = out_valid && out_ready;

  // Stage 1: capture operands and per-beat mode whenever S1 is free or advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_op  <= op;
        s1_sat <= sat_en;
      end
    end
  end

  // Per-lane arithmetic in LANE_W+1 bits so that 0 - MIN and MAX + 1 are representable;
  // overflow shows as disagreement between the extension bit and the lane sign bit.
  always_comb begin
    res_n = '0;
    ovf_n = '0;
    ax    = '0;
    bx    = '0;
    rx    = '0;
    for (int i = 0; i < LANES; i++) begin
      ax = {s1_a[i*LANE_W + LANE_W - 1], s1_a[i*LANE_W +: LANE_W]};
      bx = {s1_b[i*LANE_W + LANE_W - 1], s1_b[i*LANE_W +: LANE_W]};
      rx = s1_op ? (ax - bx) : (ax + bx);
      ovf_n[i] = rx[LANE_W] ^ rx[LANE_W-1];
      if (ovf_n[i] && s1_sat) begin
        res_n[i*LANE_W +: LANE_W] = rx[LANE_W] ? LANE_MIN : LANE_MAX;
      end else begin
        res_n[i*LANE_W +: LANE_W] = rx[LANE_W-1:0];
      end
    end
  end

  // Stage 2: output register; holds while stalled, drops valid on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum <= res_n;
        ovf <= ovf_n;
      end
    end
  end

  // Sticky overflow: clear-all on err_clr, but a lane overflowing on this handshake still sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= (err_clr ? '0 : err_sticky) | (out_fire ? ovf : '0);
    end
  end

endmodule

// File: tb/tb_psa_simd_pipe.sv
// Bench for psa_simd_pipe: queue-based reference model checked every cycle, plus literal pins.
// Latency: model expects a result two edges after the accepting cycle's capture edge chain.
// Backpressure: out_ready is stalled and toggled to exercise holding and in_ready deassertion.
module tb_psa_simd_pipe;

  localparam int LW = 4;
  localparam int LN = 4;
  localparam int DW = LW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          op = 1'b0;
  logic          sat_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] sum;
  logic [LN-1:0] ovf;
  logic [LN-1:0] err_sticky;
  logic          err_clr = 1'b0;

  // Second instance with 8-bit lanes.
  logic          in_valid8 = 1'b0;
  logic          in_ready8;
  logic [15:0]   a8 = '0;
  logic [15:0]   b8 = '0;
  logic          sat8 = 1'b0;
  logic          out_valid8;
  logic [15:0]   sum8;
  logic [1:0]    ovf8;
  logic [1:0]    sticky8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int outs = 0;

  typedef struct {
    logic [DW-1:0] s;
    logic [LN-1:0] v;
    int            t;
  } exp_t;

  exp_t          q[$];
  logic [LN-1:0] sticky_exp = '0;

  always #5 clk = ~clk;

  psa_simd_pipe #(.LANE_W(LW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  psa_simd_pipe #(.LANE_W(8), .LANES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(1'b0), .sat_en(sat8),
    .out_valid(out_valid8), .out_ready(1'b1),
    .sum(sum8), .ovf(ovf8), .err_sticky(sticky8), .err_clr(1'b0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed lane arithmetic on plain integers, then clamp or wrap.
  function automatic void model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                input logic o, input logic s,
                                output logic [DW-1:0] res, output logic [LN-1:0] v);
    int xi, yi, r;
    int mx, mn;
    mx = 2 ** (LW - 1) - 1;
    mn = -(2 ** (LW - 1));
    res = '0;
    v = '0;
    for (int i = 0; i < LN; i++) begin
      xi = int'(x[i*LW +: LW]);
      yi = int'(y[i*LW +: LW]);
      if (xi > mx) xi -= 2 ** LW;
      if (yi > mx) yi -= 2 ** LW;
      r = o ? xi - yi : xi + yi;
      v[i] = (r > mx) || (r < mn);
      if (s && r > mx) r = mx;
      else if (s && r < mn) r = mn;
      res[i*LW +: LW] = r[LW-1:0];
    end
  endfunction

  // Per-cycle compare against the model, sampled at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    logic fire;
    cyc++;
    if (rst) begin
      q.delete();
      sticky_exp = '0;
    end else begin
      exp_v = (q.size() > 0) && (cyc >= q[0].t + 2);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && !out_ready)));
      if (exp_v && out_valid) begin
        chk("sum", 32'(sum), 32'(q[0].s));
        chk("ovf", 32'(ovf), 32'(q[0].v));
      end
      chk("err_sticky", 32'(err_sticky), 32'(sticky_exp));
      fire = out_valid && out_ready && exp_v;
      if (err_clr) sticky_exp = '0;
      if (fire) begin
        e = q.pop_front();
        sticky_exp |= e.v;
        outs++;
      end
      if (in_valid && in_ready) begin
        model(a, b, op, sat_en, e.s, e.v);
        e.t = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single beat with out_ready high; returns one cycle after the result appears.
  task automatic beat(input string name, input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic o, input logic s,
                      input logic [DW-1:0] es, input logic [LN-1:0] ev);
    int n;
    in_valid = 1'b1; a = x; b = y; op = o; sat_en = s;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd1);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_ovf"}, 32'(ovf), 32'(ev));
  endtask

  // Mixed-mode vectors streamed back to back against a toggling out_ready.
  logic [DW-1:0] mix_a[8] = '{16'h1234, 16'h7F80, 16'h8888, 16'h0F0F, 16'hFFFF, 16'h7070, 16'h8008, 16'h5A5A};
  logic [DW-1:0] mix_b[8] = '{16'h4321, 16'h0180, 16'h8888, 16'hF1F1, 16'h8888, 16'h9191, 16'h7FF8, 16'hA5A5};
  logic [7:0]    rdy_pat  = 8'b1011_0110;

  initial begin
    logic fire;
    int k, guard, outs0;

    step();
    step();
    rst = 1'b0;
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sticky", 32'(err_sticky), 32'd0);

    // Saturating add, then add with overflow in every lane.
    beat("add_sat0", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000);
    beat("add_sat1", 16'h7777, 16'h1111, 1'b0, 1'b1, 16'h7777, 4'b1111);
    step();
    chk("sticky_after_ovf", 32'(err_sticky), 32'hF);

    beat("add_wrap", 16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 4'b1111);
    beat("sub_sat0", 16'h8000, 16'h1000, 1'b1, 1'b1, 16'h8000, 4'b1000);
    beat("sub_min", 16'h0000, 16'h8888, 1'b1, 1'b1, 16'h7777, 4'b1111);

    // Clear in the same cycle as an overflowing handshake in lane 1 only.
    beat("clr_set", 16'h0070, 16'h0010, 1'b0, 1'b1, 16'h0070, 4'b0010);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_set_sticky", 32'(err_sticky), 32'h2);

    // Backpressure: beats 1..5 with output stalled for the first four cycles.
    repeat (3) step();
    outs0 = outs;
    k = 1;
    guard = 0;
    in_valid = 1'b1; b = '0; op = 1'b0; sat_en = 1'b1;
    while (k <= 5 && guard < 40) begin
      out_ready = (guard >= 4);
      a = 16'(k);
      #2;
      fire = in_valid && in_ready;
      if (guard == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (guard == 3) chk("bp_sum_held", 32'(sum), 32'd1);
      step();
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("bp_count", 32'(outs - outs0), 32'd5);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Mixed modes back to back with irregular downstream readiness.
    k = 0;
    guard = 0;
    in_valid = 1'b1;
    while (k < 8 && guard < 60) begin
      a = mix_a[k]; b = mix_b[k]; op = k[0]; sat_en = k[1];
      out_ready = rdy_pat[guard % 8];
      #2;
      fire = in_valid && in_ready;
      step();
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("mix_drained", 32'(q.size()), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; op = 1'b0; sat_en = 1'b0;
    step();
    a = 16'h0002;
    step();
    in_valid = 1'b0;
    step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    outs0 = outs;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rst_no_output", 32'(outs - outs0), 32'd0);

    // 8-bit lanes: saturate then wrap.
    in_valid8 = 1'b1; a8 = 16'h7F01; b8 = 16'h0101; sat8 = 1'b1;
    step();
    sat8 = 1'b0;
    step();
    in_valid8 = 1'b0;
    chk("w8_sat_valid", 32'(out_valid8), 32'd1);
    chk("w8_sat_sum", 32'(sum8), 32'h7F02);
    chk("w8_sat_ovf", 32'(ovf8), 32'h2);
    step();
    chk("w8_wrap_valid", 32'(out_valid8), 32'd1);
    chk("w8_wrap_sum", 32'(sum8), 32'h8002);
    chk("w8_wrap_ovf", 32'(ovf8), 32'h2);
    step();
    chk("w8_idle", 32'(out_valid8), 32'd0);
    chk("w8_sticky", 32'(sticky8), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
